// File: rtl/reg_dump_reader.sv
// Walks a programmed register-file address range on the read port and streams each
// register value out over a valid/ready interface for the debug/trace dump path.
module reg_dump_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          cur_d   = first_addr;
          end_d   = last_addr;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = StIdle;
        end else begin
          out_data_d  = rdata;
          out_addr_d  = cur_q;
          out_last_d  = (cur_q == end_q);
          out_valid_d = 1'b1;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = StIdle;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            // address wraps naturally through the top of the file
            cur_d   = cur_q + ADDR_WIDTH'(1);
            state_d = StFetch;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      end_q       <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign raddr     = cur_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule
